// File: rtl/vit_pkg.sv
// Shared ViT front-end definitions: patchifier state encodings and the
// patch_streamer FSM state type.
package vit_pkg;

  localparam logic [1:0] PS_IDLE       = 2'b00;
  localparam logic [1:0] PS_PROCESSING = 2'b01;
  localparam logic [1:0] PS_DONE       = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_ACK,
    ST_WAIT
  } stream_state_e;

endpackage

// File: rtl/stream_reg_slice.sv
// Single-entry valid/ready output register. It loads whenever it is empty or
// its current beat is being taken; i_flush drops the held beat.
module stream_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_load,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/patch_streamer.sv
// Walks the patchifier's patch array once per DONE episode and streams one
// pixel per beat, then acknowledges the frame with a one-cycle output_taken.
module patch_streamer
  import vit_pkg::*;
#(
  parameter int CHANNEL_SIZE      = 8,
  parameter int NUM_CHANNELS      = 3,
  parameter int PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int IMG_WIDTH         = 64,
  parameter int IMG_HEIGHT        = 64,
  parameter int PATCH_SIZE        = 16,
  parameter int TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
  parameter int PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           patchifier_state,
  input  logic [PIXEL_WIDTH-1:0]               all_patches [TOTAL_NUM_PATCHES][PATCH_VECTOR_SIZE],
  output logic                                 output_taken,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PIXEL_WIDTH-1:0]               out_data,
  output logic [$clog2(TOTAL_NUM_PATCHES)-1:0] out_patch_idx,
  output logic [$clog2(PATCH_VECTOR_SIZE)-1:0] out_pos_idx,
  output logic                                 out_patch_last,
  output logic                                 out_frame_last,
  output logic                                 protocol_err
);

  localparam int PW = $clog2(TOTAL_NUM_PATCHES);
  localparam int QW = $clog2(PATCH_VECTOR_SIZE);
  localparam int SW = PIXEL_WIDTH + PW + QW + 2;

  localparam logic [QW-1:0] POS_LAST   = QW'(PATCH_VECTOR_SIZE - 1);
  localparam logic [PW-1:0] PATCH_LAST = PW'(TOTAL_NUM_PATCHES - 1);

  stream_state_e r_state, w_state_nxt;
  logic [PW-1:0] r_patch;
  logic [QW-1:0] r_pos;
  logic          r_err;

  logic                   w_done, w_accept, w_load;
  logic                   w_ld_valid, w_flush, w_err_set, w_cnt_en;
  logic [PW-1:0]          w_ld_patch;
  logic [QW-1:0]          w_ld_pos;
  logic                   w_ld_plast, w_ld_flast;
  logic [PIXEL_WIDTH-1:0] w_ld_data;
  logic [SW-1:0]          w_slice_q;

  assign w_done   = (patchifier_state == PS_DONE);
  assign w_accept = out_valid && out_ready;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_valid  = 1'b0;
    w_ld_patch  = r_patch;
    w_ld_pos    = r_pos;
    w_flush     = 1'b0;
    w_err_set   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_done) begin
          w_ld_valid  = 1'b1;
          w_ld_patch  = '0;
          w_ld_pos    = '0;
          w_cnt_en    = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (!w_done) begin
          w_flush     = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
          if (out_frame_last) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_ld_valid = 1'b1;
            w_cnt_en   = 1'b1;
            if (r_pos == POS_LAST) begin
              w_ld_pos   = '0;
              w_ld_patch = r_patch + 1'b1;
            end else begin
              w_ld_pos = r_pos + 1'b1;
            end
          end
        end
      end
      ST_ACK:  w_state_nxt = ST_WAIT;
      ST_WAIT: if (!w_done) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ld_data  = all_patches[w_ld_patch][w_ld_pos];
  assign w_ld_plast = (w_ld_pos == POS_LAST);
  assign w_ld_flast = w_ld_plast && (w_ld_patch == PATCH_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_patch <= '0;
      r_pos   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_en) begin
        r_patch <= w_ld_patch;
        r_pos   <= w_ld_pos;
      end
      if (w_err_set) r_err <= 1'b1;
    end
  end

  stream_reg_slice #(.W(SW)) u_slice (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_flush),
    .i_valid (w_ld_valid),
    .i_data  ({w_ld_data, w_ld_patch, w_ld_pos, w_ld_plast, w_ld_flast}),
    .i_ready (out_ready),
    .o_load  (w_load),
    .o_valid (out_valid),
    .o_data  (w_slice_q)
  );

  // The slice is always loadable when the FSM offers a beat; o_load is
  // informational only.
  logic w_unused;
  assign w_unused = w_load;

  assign {out_data, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last} = w_slice_q;
  assign output_taken = (r_state == ST_ACK);
  assign protocol_err = r_err;

endmodule

// File: tb/tb_patch_streamer.sv
// Scoreboard bench for patch_streamer: expected beats are queued per frame and
// popped on every accepted beat.
module tb_patch_streamer;

  localparam int NP = 16;
  localparam int NV = 256;
  localparam int FRAME = NP * NV;
  localparam int BUDGET = 20000;
  localparam logic [1:0] P_IDLE = 2'b00;
  localparam logic [1:0] P_DONE = 2'b10;

  typedef struct packed {
    logic [23:0] data;
    logic [3:0]  patch;
    logic [7:0]  pos;
    logic        plast;
    logic        flast;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  patchifier_state = P_IDLE;
  logic [23:0] all_patches [NP][NV];
  logic        output_taken, out_valid, out_ready = 1'b1;
  logic [23:0] out_data;
  logic [3:0]  out_patch_idx;
  logic [7:0]  out_pos_idx;
  logic        out_patch_last, out_frame_last, protocol_err;

  int n_assert = 0;
  int n_fail   = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  patch_streamer dut (
    .clk              (clk),
    .reset            (reset),
    .patchifier_state (patchifier_state),
    .all_patches      (all_patches),
    .output_taken     (output_taken),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_patch_idx    (out_patch_idx),
    .out_pos_idx      (out_pos_idx),
    .out_patch_last   (out_patch_last),
    .out_frame_last   (out_frame_last),
    .protocol_err     (protocol_err)
  );

  task automatic load_expected();
    beat_t b;
    sb.delete();
    for (int p = 0; p < NP; p++)
      for (int q = 0; q < NV; q++) begin
        b.data  = 24'((p << 8) | q);
        b.patch = 4'(p);
        b.pos   = 8'(q);
        b.plast = (q == NV - 1);
        b.flast = (q == NV - 1) && (p == NP - 1);
        sb.push_back(b);
      end
  endtask

  // Consumes beats until the frame-last beat is accepted, or returns early
  // (before driving ready) once stop_beat beats have been accepted.
  task automatic consume(input bit rnd, input int stop_beat, output int beats, output int cycles);
    beat_t got, exp, held;
    bit stalled, fin;
    beats = 0; cycles = 0; stalled = 0; fin = 0; held = '0;
    while (!fin) begin
      @(negedge clk);
      cycles++;
      if (beats == stop_beat) return;
      if (cycles > BUDGET) begin
        n_assert++; n_fail++;
        $display("FAIL consume_timeout: beats=%0d after %0d cycles", beats, cycles);
        return;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      got = {out_data, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last};
      if (stalled) begin
        n_assert++;
        if (got !== held) begin
          n_fail++;
          $display("FAIL stall_hold: got %h required %h", got, held);
        end
      end
      n_assert++;
      if (output_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL taken_mid_stream: got %b required 0 at beat %0d", output_taken, beats);
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got %h required none", got);
          fin = 1;
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL beat_%0d: got %h required %h", beats, got, exp);
          end
        end
        beats++;
        if (got.flast) fin = 1;
        stalled = 0;
      end else begin
        stalled = (out_valid === 1'b1);
        held = got;
      end
    end
  endtask

  task automatic check_ack();
    @(negedge clk);
    n_assert++;
    if ({output_taken, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL ack_cycle: taken/valid got %b required 10", {output_taken, out_valid});
    end
    @(negedge clk);
    n_assert++;
    if (output_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_single: got %b required 0", output_taken);
    end
  endtask

  task automatic go_idle();
    patchifier_state = P_IDLE;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_assert++;
    if ({out_valid, out_data, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last,
         output_taken, protocol_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b data=%h patch=%0d pos=%0d taken=%b err=%b required all 0",
               out_valid, out_data, out_patch_idx, out_pos_idx, output_taken, protocol_err);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_beat: got %b required 0", out_valid);
    end
  endtask

  task automatic test_full_frame();
    int beats, cycles;
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b0, -1, beats, cycles);
    n_assert++;
    if (beats != FRAME || cycles != FRAME) begin
      n_fail++;
      $display("FAIL full_frame_count: beats=%0d cycles=%0d required %0d", beats, cycles, FRAME);
    end
    check_ack();
  endtask

  task automatic test_rearm_guard();
    int beats, cycles;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_assert++;
      if ({out_valid, output_taken} !== 2'b00) begin
        n_fail++;
        $display("FAIL rearm_hold_%0d: valid/taken got %b required 00", i, {out_valid, output_taken});
      end
    end
    go_idle();
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b0, -1, beats, cycles);
    n_assert++;
    if (beats != FRAME) begin
      n_fail++;
      $display("FAIL rearm_frame: beats=%0d required %0d", beats, FRAME);
    end
    check_ack();
  endtask

  task automatic test_backpressure();
    int beats, cycles;
    go_idle();
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b1, -1, beats, cycles);
    n_assert++;
    if (beats != FRAME || sb.size() != 0 || protocol_err !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_frame: beats=%0d left=%0d err=%b required %0d 0 0",
               beats, sb.size(), protocol_err, FRAME);
    end
    check_ack();
  endtask

  task automatic test_abort();
    int beats, cycles;
    go_idle();
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b0, 100, beats, cycles);
    patchifier_state = P_IDLE;
    @(negedge clk);
    n_assert++;
    if ({protocol_err, out_valid, output_taken} !== 3'b100) begin
      n_fail++;
      $display("FAIL abort_next: err/valid/taken got %b required 100",
               {protocol_err, out_valid, output_taken});
    end
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_assert++;
      if ({protocol_err, output_taken} !== 2'b10) begin
        n_fail++;
        $display("FAIL abort_sticky_%0d: err/taken got %b required 10", i, {protocol_err, output_taken});
      end
    end
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b0, -1, beats, cycles);
    check_ack();
    n_assert++;
    if (protocol_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_persists: got %b required 1", protocol_err);
    end
  endtask

  task automatic test_reset_midstream();
    int beats, cycles;
    go_idle();
    load_expected();
    patchifier_state = P_DONE;
    consume(1'b0, 2000, beats, cycles);
    reset = 1'b0;
    #1;
    n_assert++;
    if ({out_valid, out_data, out_patch_idx, out_pos_idx, out_patch_last, out_frame_last,
         output_taken, protocol_err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h patch=%0d pos=%0d err=%b required all 0",
               out_valid, out_data, out_patch_idx, out_pos_idx, protocol_err);
    end
    @(negedge clk);
    reset = 1'b1;
    load_expected();
    consume(1'b0, -1, beats, cycles);
    n_assert++;
    if (beats != FRAME || cycles != FRAME) begin
      n_fail++;
      $display("FAIL restart_frame: beats=%0d cycles=%0d required %0d", beats, cycles, FRAME);
    end
    check_ack();
  endtask

  initial begin
    for (int p = 0; p < NP; p++)
      for (int q = 0; q < NV; q++)
        all_patches[p][q] = 24'((p << 8) | q);
    test_reset();
    test_full_frame();
    test_rearm_guard();
    test_backpressure();
    test_abort();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
